// File: rtl/bit_selection_pkg.sv
// bit_selection_pkg
//   Shared constants for the 16->8 bit selection block: bus widths, the
//   command field layout and the dummy byte driven when no valid data
//   is present.
//   Optional build macro used by the top: BIT_SELECTION_ASSERT_EN.
package bit_selection_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int COMMAND_WIDTH  = 4;                 // $clog2(DATA_WIDTH)
  localparam int OUT_DATA_WIDTH = DATA_WIDTH / 2;    // 8

  // Command layout: cmd[3] enables the shift, cmd[2:0] is shift code k.
  localparam int SHIFT_EN_BIT   = 3;
  localparam int SHIFT_CODE_MSB = 2;
  localparam int SHIFT_CODE_LSB = 0;
  localparam int SHIFT_CODE_W   = SHIFT_CODE_MSB - SHIFT_CODE_LSB + 1;

  // Byte presented whenever the output is not valid.
  localparam logic [OUT_DATA_WIDTH-1:0] DUMMY_DATA = 8'h00;

  // Shift-amount width: large enough to hold k+1 (1..8).
  localparam int SHAMT_W = SHIFT_CODE_W + 1;

endpackage

// File: rtl/bit_selection_16x8_comb.sv
// bit_selection_16x8_comb
//   Purely combinational 16->8 selector.
//     cmd[3]=0 : sel = data[7:0]           (k ignored)
//     cmd[3]=1 : sel = data[k+8:k+1]       (right shift by k+1, 1..8)
//   Bit order inside the byte is preserved.
// Ports:
//   data [DATA_WIDTH-1:0]     source word
//   cmd  [COMMAND_WIDTH-1:0]  {shift_en, k[2:0]}
//   sel  [OUT_DATA_WIDTH-1:0] selected byte
module bit_selection_16x8_comb
  import bit_selection_pkg::*;
#(
  parameter int DATA_WIDTH    = bit_selection_pkg::DATA_WIDTH,
  parameter int COMMAND_WIDTH = bit_selection_pkg::COMMAND_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]      data,
  input  logic [COMMAND_WIDTH-1:0]   cmd,
  output logic [DATA_WIDTH/2-1:0]    sel
);

  localparam int OUT_W = DATA_WIDTH / 2;

  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] shifted;

  // k+1 is computed in SHAMT_W bits so k=7 gives 8 rather than wrapping to 0.
  always_comb begin
    shamt = '0;
    if (cmd[SHIFT_EN_BIT])
      shamt = {1'b0, cmd[SHIFT_CODE_MSB:SHIFT_CODE_LSB]} + SHAMT_W'(1);
  end

  // Logical right shift; the largest shift (8) still leaves a full byte
  // of real source bits in the low half, so zero fill never reaches sel.
  assign shifted = data >> shamt;

  // One output bit per generate iteration keeps the byte order explicit.
  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    assign sel[i] = shifted[i];
  end

endmodule

// File: rtl/bit_selection_16x8_seq.sv
// bit_selection_16x8_seq
//   Registered 16->8 bit selector, one-cycle latency, throughput 1/clock,
//   no back-pressure. The only state is the output register pair.
//   Optional macro BIT_SELECTION_ASSERT_EN compiles in simulation
//   assertions; without it no assertion code exists and behaviour is
//   identical.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (clears outputs immediately)
//   i_valid    input qualifier
//   i_data_bus [DATA_WIDTH-1:0] source word
//   i_en       clock enable; 0 holds the outputs
//   i_cmd      [COMMAND_WIDTH-1:0] {shift_en, k}
//   o_valid    registered output qualifier
//   o_data_bus [DATA_WIDTH/2-1:0] registered byte (DUMMY_DATA when !o_valid)
module bit_selection_16x8_seq
  import bit_selection_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,  // only 16 supported
  parameter int COMMAND_WIDTH = 4    // only 4 supported
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  input  logic [DATA_WIDTH-1:0]      i_data_bus,
  input  logic                       i_en,
  input  logic [COMMAND_WIDTH-1:0]   i_cmd,
  output logic                       o_valid,
  output logic [DATA_WIDTH/2-1:0]    o_data_bus
);

  localparam int OUT_DATA_W = DATA_WIDTH / 2;
  localparam int STAGES     = 1;

  logic [OUT_DATA_W-1:0] sel;
  logic [OUT_DATA_W-1:0] data_q;
  // vld_pipe[0] is the incoming qualifier; vld_pipe[STAGES] is the register.
  logic [STAGES:0]       vld_pipe;

  bit_selection_16x8_comb #(
    .DATA_WIDTH    (DATA_WIDTH),
    .COMMAND_WIDTH (COMMAND_WIDTH)
  ) u_comb (
    .data (i_data_bus),
    .cmd  (i_cmd),
    .sel  (sel)
  );

  assign vld_pipe[0] = i_valid;

  // The data register is forced to the dummy byte on invalid input so that
  // stale bytes never sit behind o_valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      data_q             <= DUMMY_DATA;
    end else if (i_en) begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      data_q             <= i_valid ? sel : DUMMY_DATA;
    end
  end

  assign o_valid    = vld_pipe[STAGES];
  assign o_data_bus = data_q;

`ifdef BIT_SELECTION_ASSERT_EN
  a_dummy_when_invalid : assert property (
    @(posedge clk) disable iff (!rst_n) !o_valid |-> (o_data_bus == DUMMY_DATA));

  a_inputs_known : assert property (
    @(posedge clk) disable iff (!rst_n)
    (i_en && i_valid) |-> !$isunknown({i_cmd, i_data_bus}));

  a_reset_clears_valid : assert property (
    @(posedge clk) !rst_n |-> !o_valid);
`else
`endif

endmodule

// File: tb/tb_bit_selection_16x8_seq.sv
module tb_bit_selection_16x8_seq;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [15:0] i_data_bus;
  logic        i_en;
  logic [3:0]  i_cmd;
  logic        o_valid;
  logic [7:0]  o_data_bus;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        en;
    logic        vld;
    logic [15:0] d;
    logic [3:0]  cmd;
    logic        exp_v;
    logic [7:0]  exp_d;
  } vec_t;

  typedef struct {
    string      name;
    logic       v;
    logic [7:0] d;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  bit_selection_16x8_seq #(.DATA_WIDTH(16), .COMMAND_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_en       (i_en),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick bits individually, k+1 offset when shift is enabled.
  function automatic logic [7:0] model(input logic vld, input logic [15:0] d,
                                       input logic [3:0] cmd);
    logic [7:0] r;
    int off;
    r = 8'h00;
    if (vld) begin
      off = cmd[3] ? int'(cmd[2:0]) + 1 : 0;
      for (int i = 0; i < 8; i++) r[i] = d[i + off];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, push expectation, compare after the edge.
  task automatic step(input string name, input logic en, input logic vld,
                      input logic [15:0] d, input logic [3:0] cmd,
                      input logic ev, input logic [7:0] ed);
    exp_t e;
    i_en = en; i_valid = vld; i_data_bus = d; i_cmd = cmd;
    e.name = name; e.v = ev; e.d = ed;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check({e.name, "_valid"}, {7'd0, o_valid}, {7'd0, e.v});
      check({e.name, "_data"}, o_data_bus, e.d);
    end
  endtask

  function automatic vec_t mk(input string n, input logic en, input logic vld,
                              input logic [15:0] d, input logic [3:0] cmd,
                              input logic ev, input logic [7:0] ed);
    vec_t v;
    v.name = n; v.en = en; v.vld = vld; v.d = d; v.cmd = cmd;
    v.exp_v = ev; v.exp_d = ed;
    return v;
  endfunction

  initial begin
    logic [15:0] rd;
    logic [3:0]  rc;
    logic        rv;

    tbl.push_back(mk("noshift_0000", 1, 1, 16'hA442, 4'b0000, 1, 8'h42));
    tbl.push_back(mk("sh1_1000",     1, 1, 16'hA442, 4'b1000, 1, 8'h21));
    tbl.push_back(mk("sh2_1001",     1, 1, 16'hA442, 4'b1001, 1, 8'h10));
    tbl.push_back(mk("sh3_1010",     1, 1, 16'hA442, 4'b1010, 1, 8'h88));
    tbl.push_back(mk("sh4_1011",     1, 1, 16'hA442, 4'b1011, 1, 8'h44));
    tbl.push_back(mk("sh5_1100",     1, 1, 16'hA442, 4'b1100, 1, 8'h22));
    tbl.push_back(mk("sh6_1101",     1, 1, 16'hA442, 4'b1101, 1, 8'h91));
    tbl.push_back(mk("sh7_1110",     1, 1, 16'hA442, 4'b1110, 1, 8'h48));
    tbl.push_back(mk("sh8_1111",     1, 1, 16'hA442, 4'b1111, 1, 8'hA4));
    tbl.push_back(mk("k_ignored_0101", 1, 1, 16'hA442, 4'b0101, 1, 8'h42));
    tbl.push_back(mk("invalid",      1, 0, 16'hA442, 4'b1011, 0, 8'h00));
    // Hold sequence: capture A4, then three disabled cycles.
    tbl.push_back(mk("cap_A4",       1, 1, 16'hA442, 4'b1111, 1, 8'hA4));
    tbl.push_back(mk("hold1",        0, 1, 16'hA442, 4'b0000, 1, 8'hA4));
    tbl.push_back(mk("hold2",        0, 0, 16'hFFFF, 4'b0000, 1, 8'hA4));
    tbl.push_back(mk("hold3",        0, 1, 16'h0000, 4'b0000, 1, 8'hA4));
    // Hold of an invalid output keeps valid low and data at dummy.
    tbl.push_back(mk("invalid2",     1, 0, 16'h1234, 4'b0000, 0, 8'h00));
    tbl.push_back(mk("hold_inv",     0, 1, 16'h1234, 4'b0000, 0, 8'h00));
    tbl.push_back(mk("sh8_top",      1, 1, 16'hFF00, 4'b1111, 1, 8'hFF));

    // Reset state, with the clock running and inputs active.
    rst_n = 1'b0; i_en = 1'b1; i_valid = 1'b1; i_data_bus = 16'hA442; i_cmd = 4'b1000;
    #1;
    check("reset_valid", {7'd0, o_valid}, 8'h00);
    check("reset_data", o_data_bus, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_valid", {7'd0, o_valid}, 8'h00);
    check("reset_held_data", o_data_bus, 8'h00);
    #2 rst_n = 1'b1;

    foreach (tbl[i])
      step(tbl[i].name, tbl[i].en, tbl[i].vld, tbl[i].d, tbl[i].cmd,
           tbl[i].exp_v, tbl[i].exp_d);

    // Mid-stream async reset while o_data_bus = 21.
    step("pre_rst_21", 1, 1, 16'hA442, 4'b1000, 1, 8'h21);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {7'd0, o_valid}, 8'h00);
    check("async_rst_data", o_data_bus, 8'h00);
    #2 rst_n = 1'b1;
    step("post_rst_21", 1, 1, 16'hA442, 4'b1000, 1, 8'h21);

    // Random vectors against the reference model.
    for (int n = 0; n < 24; n++) begin
      rd = 16'($urandom);
      rc = 4'($urandom);
      rv = 1'($urandom_range(0, 3) != 0);
      step($sformatf("rand%0d", n), 1, rv, rd, rc, rv, model(rv, rd, rc));
    end

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_selection_16x8_seq.md
BIT_SELECTION_16X8_SEQ -- requirements
Module: bit_selection_16x8_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, input bus width; only 16 is supported.
REQ-002 The block SHALL have parameter COMMAND_WIDTH, default 4, command width ($clog2(DATA_WIDTH)); only 4 is supported.
REQ-003 The block SHALL derive local constant OUT_DATA_WIDTH = DATA_WIDTH/2 (8).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port i_valid, input, 1 bit: input data/command qualifier.
REQ-007 The block SHALL have port i_data_bus, input, DATA_WIDTH bits: source word.
REQ-008 The block SHALL have port i_en, input, 1 bit: block clock-enable.
REQ-009 The block SHALL have port i_cmd, input, COMMAND_WIDTH bits: i_cmd[3] = shift enable, i_cmd[2:0] = shift code k.
REQ-010 The block SHALL have port o_valid, output, 1 bit: registered output qualifier.
REQ-011 The block SHALL have port o_data_bus, output, OUT_DATA_WIDTH bits: registered selected byte.

Function
REQ-012 The block SHALL select 8 contiguous bits of i_data_bus: i_cmd[3]=0 -> i_data_bus[7:0]; i_cmd[3]=1 -> i_data_bus[k+8:k+1], i.e. right shift by k+1 (1..8), low 8 bits kept.
REQ-013 With i_cmd[3]=0, i_cmd[2:0] SHALL be ignored (no shift).
REQ-014 Bit order within the selected byte SHALL be preserved (no reversal).
REQ-015 Latency SHALL be exactly one clock: outputs reflect inputs sampled at the previous rising edge.
REQ-016 On a rising edge with i_en=1 and i_valid=1, o_valid SHALL become 1 and o_data_bus the selected byte.
REQ-017 On a rising edge with i_en=1 and i_valid=0, o_valid SHALL become 0 and o_data_bus the dummy value 8'h00.
REQ-018 On a rising edge with i_en=0, o_valid and o_data_bus SHALL hold their values.
REQ-019 There SHALL be no back-pressure; a new selection is accepted every enabled cycle (throughput 1/clock).
REQ-020 The block SHALL contain no other state beyond the output registers.

Reset
REQ-021 rst_n=0 SHALL immediately (asynchronously) force o_valid=0 and o_data_bus=8'h00, independent of clk, i_en and i_valid.
REQ-022 While rst_n=0, inputs SHALL be ignored; the first capture occurs on the first rising edge after rst_n deasserts.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight result with no residual effect.

Configuration
REQ-024 When macro BIT_SELECTION_ASSERT_EN is defined, the block SHALL include simulation assertions: o_valid=0 implies o_data_bus=8'h00; i_cmd and i_data_bus are not X/Z when i_en=1 and i_valid=1; o_valid=0 while rst_n=0.
REQ-025 Without BIT_SELECTION_ASSERT_EN, no assertion code SHALL be compiled, and functional behaviour SHALL be identical.

Structure
REQ-026 A shared package bit_selection_pkg SHALL hold DATA_WIDTH/COMMAND_WIDTH/OUT_DATA_WIDTH constants, the shift-enable bit index (3), the shift-code field range [2:0], and the dummy value 8'h00.
REQ-027 The combinational 16-to-8 selector SHALL be a sub-module named bit_selection_16x8_comb; the top adds only the enable/valid/reset output register stage.

Verification
REQ-028 The bench SHALL drive i_data_bus=16'hA442, i_valid=1, i_en=1 with i_cmd=4'b0000, then 1000, 1001, 1010, 1011, and check o_data_bus one cycle later is 42, 21, 10, 88, 44 (hex) with o_valid=1.
REQ-029 The bench SHALL use the same data with i_cmd=4'b1100, 1101, 1110, 1111 and check o_data_bus = 22, 91, 48, A4; also check i_cmd=4'b0101 gives 42.
REQ-030 The bench SHALL apply i_valid=0, i_en=1, any cmd, and check o_valid=0 and o_data_bus=00 next cycle.
REQ-031 The bench SHALL capture A4 (cmd 1111), then drive i_en=0 with i_cmd=0000 for 3 cycles, and check o_data_bus stays A4 and o_valid stays 1.
REQ-032 The bench SHALL assert rst_n=0 between clock edges while o_data_bus=21, and check o_data_bus=00 and o_valid=0 before the next edge; after release with cmd 1000, check 21 one cycle later.
